// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the camera frame-capture block.
//   cam_state_e : capture state machine encoding
//   cam_fmt_e   : output pixel format selector (fmt input)
//   cam_dec_e   : decimation selector (dec input)
//   pack_pixel  : converts a sensor byte pair into the 16-bit buffer word
//   keep_pixel  : decimation filter on the low bits of column/row
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT_VS = 2'b01,
        ST_ACTIVE  = 2'b10,
        ST_DONE    = 2'b11
    } cam_state_e;

    // Code 11 behaves exactly like RGB565.
    typedef enum logic [1:0] {
        FMT_RGB565 = 2'b00,
        FMT_RGB444 = 2'b01,
        FMT_Y8     = 2'b10,
        FMT_ALT565 = 2'b11
    } cam_fmt_e;

    // Code 11 behaves exactly like divide-by-4.
    typedef enum logic [1:0] {
        DEC_NONE    = 2'b00,
        DEC_HALF    = 2'b01,
        DEC_QUARTER = 2'b10,
        DEC_ALTQ    = 2'b11
    } cam_dec_e;

    // hi is the first (phase-0) byte of a pixel, lo the second.
    function automatic logic [15:0] pack_pixel(input logic [1:0] fmt,
                                               input logic [7:0] hi,
                                               input logic [7:0] lo);
        logic [15:0] pix;
        case (cam_fmt_e'(fmt))
            FMT_RGB444: pix = {4'b0000, hi[7:4], hi[2:0], lo[7], lo[4:1]};
            FMT_Y8:     pix = {8'h00, hi};
            default:    pix = {hi, lo};
        endcase
        return pix;
    endfunction

    // A pixel survives decimation when the low k bits of both column and row are zero.
    function automatic logic keep_pixel(input logic [1:0] dec,
                                        input logic [1:0] col,
                                        input logic [1:0] row);
        logic keep;
        case (cam_dec_e'(dec))
            DEC_NONE: keep = 1'b1;
            DEC_HALF: keep = (col[0] == 1'b0) && (row[0] == 1'b0);
            default:  keep = (col == 2'b00) && (row == 2'b00);
        endcase
        return keep;
    endfunction

endpackage

// File: rtl/cam_pixel_pack.sv
// cam_pixel_pack: combinational byte-pair to buffer-word conversion.
//   i_fmt : output format code (cam_fmt_e encoding)
//   i_hi  : phase-0 byte of the pixel
//   i_lo  : phase-1 byte of the pixel
//   o_pix : packed 16-bit pixel word
module cam_pixel_pack
    import cam_pkg::*;
(
    input  logic [1:0]  i_fmt,
    input  logic [7:0]  i_hi,
    input  logic [7:0]  i_lo,
    output logic [15:0] o_pix
);

    assign o_pix = pack_pixel(i_fmt, i_hi, i_lo);

endmodule

// File: rtl/cam_frame_capture.sv
// cam_frame_capture: captures one sensor frame (vsync/href/byte bus) into a
// frame buffer, with format conversion, decimation and overflow detection.
//   clk, reset        : pixel clock, asynchronous active-high reset
//   vsync, href, d    : sensor frame blanking, line valid, data byte
//   fmt, dec          : output format and decimation, latched at frame start
//   single, arm       : single-shot mode and its capture request pulse
//   we, addr, dout    : registered frame-buffer write port
//   frame_done        : one-cycle pulse at the end of each captured frame
//   busy              : waiting for or receiving a frame
//   overflow          : sticky, a kept pixel found the buffer already full
module cam_frame_capture
    import cam_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 76800,
    parameter int LINE_W = 640
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic [1:0]        fmt,
    input  logic [1:0]        dec,
    input  logic              single,
    input  logic              arm,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout,
    output logic              frame_done,
    output logic              busy,
    output logic              overflow
);

    localparam int COL_W = $clog2(LINE_W);
    localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LINE_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    cam_state_e        r_state;
    cam_state_e        w_next;
    logic              w_start;
    logic              r_vs_seen;
    logic [1:0]        r_fmt;
    logic [1:0]        r_dec;
    logic              r_phase;
    logic [7:0]        r_hi;
    logic [COL_W-1:0]  r_col;
    logic              r_col_full;
    // Only the low two row bits matter for decimation, so the row counter wraps.
    logic [1:0]        r_row;
    logic              r_href_d;
    logic [ADDR_W-1:0] r_wptr;
    logic              r_mem_full;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_dout;
    logic              r_frame_done;
    logic              r_busy;
    logic              r_overflow;
    logic              w_keep;
    logic [15:0]       w_pix;

    cam_pixel_pack u_pack (
        .i_fmt (r_fmt),
        .i_hi  (r_hi),
        .i_lo  (d),
        .o_pix (w_pix)
    );

    // Next-state decode for the capture state machine.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!single || arm) begin
                    w_next = ST_WAIT_VS;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT_VS: begin
                if (r_vs_seen && !vsync) begin
                    w_next  = ST_ACTIVE;
                    w_start = 1'b1;
                end else begin
                    w_next = ST_WAIT_VS;
                end
            end
            ST_ACTIVE: begin
                if (vsync) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_ACTIVE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // A pixel is written when its second byte arrives, it passes decimation
    // and its column is still inside the line width.
    assign w_keep = (r_state == ST_ACTIVE) && href && r_phase && !r_col_full &&
                    keep_pixel(r_dec, r_col[1:0], r_row);

    // State register plus the "vsync seen high" qualifier for frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_vs_seen <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_vs_seen <= (r_state == ST_WAIT_VS) && (r_vs_seen || vsync);
        end
    end

    // Delayed href for falling-edge (end of line) detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_href_d <= 1'b0;
        end else begin
            r_href_d <= href;
        end
    end

    // Byte phase, column and row tracking; fmt/dec are frozen for the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase    <= 1'b0;
            r_hi       <= 8'h00;
            r_col      <= '0;
            r_col_full <= 1'b0;
            r_row      <= 2'b00;
            r_fmt      <= 2'b00;
            r_dec      <= 2'b00;
        end else if (w_start) begin
            r_phase    <= 1'b0;
            r_col      <= '0;
            r_col_full <= 1'b0;
            r_row      <= 2'b00;
            r_fmt      <= fmt;
            r_dec      <= dec;
        end else if (r_state == ST_ACTIVE) begin
            if (href) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_hi <= d;
                end else if (!r_col_full) begin
                    // The last in-range column marks the line full instead of
                    // wrapping, so later pixels on this line are dropped.
                    if (r_col == LAST_COL) begin
                        r_col_full <= 1'b1;
                    end else begin
                        r_col <= r_col + COL_ONE;
                    end
                end
            end else begin
                // A dangling phase-0 byte is simply forgotten here.
                r_phase    <= 1'b0;
                r_col      <= '0;
                r_col_full <= 1'b0;
            end
            if (r_href_d && !href) begin
                r_row <= r_row + 2'b01;
            end
        end
    end

    // Frame-buffer write port, write pointer and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_dout     <= 16'h0000;
            r_wptr     <= '0;
            r_mem_full <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_start) begin
                r_wptr     <= '0;
                r_mem_full <= 1'b0;
                r_overflow <= 1'b0;
            end else if (w_keep) begin
                if (r_mem_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_we   <= 1'b1;
                    r_addr <= r_wptr;
                    r_dout <= w_pix;
                    if (r_wptr == LAST_ADDR) begin
                        r_mem_full <= 1'b1;
                    end else begin
                        r_wptr <= r_wptr + ADDR_ONE;
                    end
                end
            end
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_done <= (w_next == ST_DONE);
            r_busy       <= (w_next == ST_WAIT_VS) || (w_next == ST_ACTIVE);
        end
    end

    assign we         = r_we;
    assign addr       = r_addr;
    assign dout       = r_dout;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_cam_frame_capture.sv
// tb_cam_frame_capture: self-checking bench for cam_frame_capture.
// Two instances share all inputs: one full-size buffer and one with DEPTH=10
// so every frame also exercises the overflow path.
module tb_cam_frame_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic [1:0]  fmt;
    logic [1:0]  dec;
    logic        single;
    logic        arm;
    logic        we,         s_we;
    logic [16:0] addr,       s_addr;
    logic [15:0] dout,       s_dout;
    logic        frame_done, s_frame_done;
    logic        busy,       s_busy;
    logic        overflow,   s_overflow;

    always #5 clk = ~clk;

    cam_frame_capture #(.ADDR_W(17), .DEPTH(76800), .LINE_W(640)) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .href(href), .d(d),
        .fmt(fmt), .dec(dec), .single(single), .arm(arm),
        .we(we), .addr(addr), .dout(dout),
        .frame_done(frame_done), .busy(busy), .overflow(overflow)
    );

    cam_frame_capture #(.ADDR_W(17), .DEPTH(10), .LINE_W(640)) dut_s (
        .clk(clk), .reset(reset), .vsync(vsync), .href(href), .d(d),
        .fmt(fmt), .dec(dec), .single(single), .arm(arm),
        .we(s_we), .addr(s_addr), .dout(s_dout),
        .frame_done(s_frame_done), .busy(s_busy), .overflow(s_overflow)
    );

    int checks = 0;
    int errors = 0;

    // Captured writes and frame_done cycles, sampled on the falling edge.
    int got_a[$];
    int got_d[$];
    int sgot_a[$];
    int sgot_d[$];
    int done_cnt  = 0;
    int sdone_cnt = 0;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            got_a.push_back(int'(addr));
            got_d.push_back(int'(dout));
        end
        if (s_we === 1'b1) begin
            sgot_a.push_back(int'(s_addr));
            sgot_d.push_back(int'(s_dout));
        end
        if (frame_done === 1'b1) done_cnt++;
        if (s_frame_done === 1'b1) sdone_cnt++;
    end

    // Frame content: fb[line][byte]; kept[] is the model's list of written words.
    int fb [8][16];
    int nl;
    int nb;
    int kept[$];
    int ns;

    function automatic int px(input int hi, input int lo, input int f);
        case (f)
            1:       return ((hi / 16) * 256) + ((hi % 8) * 32) + ((lo / 128) * 16) + ((lo / 2) % 16);
            2:       return hi;
            default: return hi * 256 + lo;
        endcase
    endfunction

    // Reference model: walk the pixel grid with plain arithmetic.
    task automatic model_frame(input int f, input int dc);
        int step;
        kept.delete();
        step = (dc == 0) ? 1 : ((dc == 1) ? 2 : 4);
        for (int r = 0; r < nl; r++) begin
            for (int c = 0; c < nb / 2; c++) begin
                if (c < 640 && (r % step) == 0 && (c % step) == 0) begin
                    kept.push_back(px(fb[r][2*c], fb[r][2*c+1], f));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_frame(input int lines, input int bytes);
        nl = lines;
        nb = bytes;
        for (int l = 0; l < 8; l++) begin
            for (int b = 0; b < 16; b++) begin
                fb[l][b] = int'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic clear_capture();
        got_a.delete(); got_d.delete();
        sgot_a.delete(); sgot_d.delete();
        done_cnt  = 0;
        sdone_cnt = 0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Blanking, frame start, lines, then blanking again. fmt/dec are scrambled
    // once the frame has started to confirm they are latched at frame start.
    task automatic drive_frame(input bit arm_mid, input bit vs_last);
        vsync = 1'b1; href = 1'b0;
        repeat (4) tick();
        vsync = 1'b0;
        repeat (3) tick();
        fmt = 2'($urandom_range(0, 3));
        dec = 2'($urandom_range(0, 3));
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < nb; b++) begin
                href = 1'b1;
                d    = 8'(fb[l][b]);
                arm  = (arm_mid && l == 1 && b == 0) ? 1'b1 : 1'b0;
                if (vs_last && l == nl - 1 && b == nb - 1) vsync = 1'b1;
                tick();
            end
            href = 1'b0;
            arm  = 1'b0;
            d    = 8'($urandom_range(0, 255));
            if (!(vs_last && l == nl - 1)) repeat (3) tick();
        end
        vsync = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; vsync = 1'b1; href = 1'b0; d = 8'h00;
        fmt = 2'b00; dec = 2'b00; single = 1'b1; arm = 1'b0;
        repeat (3) tick();
        checks++;
        if ({we, addr, dout, frame_done, busy, overflow} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%0d dout=%h done=%b busy=%b ovf=%b, expected all 0",
                     we, addr, dout, frame_done, busy, overflow);
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_not_busy: got busy=%b/%b, expected 0", busy, s_busy);
        end
    endtask

    // 4x4 RGB565 frame: full-size buffer gets 16 words, DEPTH=10 buffer overflows.
    task automatic test_basic(input string tag, input int lines, input int bytes, input int f, input int dc);
        fmt = 2'(f); dec = 2'(dc);
        model_frame(f, dc);
        clear_capture();
        pulse_arm();
        drive_frame(1'b0, 1'b0);
        checks++;
        if (got_a.size() !== kept.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d writes, expected %0d", tag, got_a.size(), kept.size());
        end
        for (int i = 0; i < got_a.size() && i < kept.size(); i++) begin
            checks++;
            if (got_a[i] !== i || got_d[i] !== kept[i]) begin
                errors++;
                $display("FAIL %s_write[%0d]: got addr %0d dout %h, expected addr %0d dout %h",
                         tag, i, got_a[i], got_d[i], i, kept[i]);
            end
        end
        ns = (kept.size() < 10) ? kept.size() : 10;
        checks++;
        if (sgot_a.size() !== ns) begin
            errors++;
            $display("FAIL %s_small_count: got %0d writes, expected %0d", tag, sgot_a.size(), ns);
        end
        for (int i = 0; i < sgot_a.size() && i < ns; i++) begin
            checks++;
            if (sgot_a[i] !== i || sgot_d[i] !== kept[i]) begin
                errors++;
                $display("FAIL %s_small_write[%0d]: got addr %0d dout %h, expected addr %0d dout %h",
                         tag, i, sgot_a[i], sgot_d[i], i, kept[i]);
            end
        end
        checks++;
        if (s_overflow !== (kept.size() > 10) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL %s_overflow: got %b/%b, expected 0/%b", tag, overflow, s_overflow, kept.size() > 10);
        end
        checks++;
        if (done_cnt !== 1 || sdone_cnt !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: got pulses %0d/%0d busy %b, expected 1/1 busy 0", tag, done_cnt, sdone_cnt, busy);
        end
    endtask

    task automatic test_formats();
        gen_frame(1, 4);
        fb[0][0] = 8'hF8; fb[0][1] = 8'h1F;
        fmt = 2'b01; dec = 2'b00;
        clear_capture();
        pulse_arm();
        drive_frame(1'b0, 1'b0);
        checks++;
        if (got_d.size() < 1 || got_d[0] !== 16'h0F0F) begin
            errors++;
            $display("FAIL fmt_rgb444: got %0d writes first %h, expected dout 0f0f", got_d.size(),
                     (got_d.size() > 0) ? got_d[0] : -1);
        end
        gen_frame(1, 4);
        fb[0][0] = 8'h5A;
        fmt = 2'b10; dec = 2'b00;
        clear_capture();
        pulse_arm();
        drive_frame(1'b0, 1'b0);
        checks++;
        if (got_d.size() < 1 || got_d[0] !== 16'h005A) begin
            errors++;
            $display("FAIL fmt_y8: got %0d writes first %h, expected dout 005a", got_d.size(),
                     (got_d.size() > 0) ? got_d[0] : -1);
        end
    endtask

    // Odd byte count per line plus an arm pulse during ACTIVE, then confirm
    // that the ignored arm did not queue a second capture.
    task automatic test_partial_arm();
        gen_frame(3, 7);
        test_basic("partial", 3, 7, 0, 0);
        gen_frame(4, 8);
        fmt = 2'b00; dec = 2'b00;
        clear_capture();
        pulse_arm();
        drive_frame(1'b1, 1'b0);
        gen_frame(2, 4);
        clear_capture();
        drive_frame(1'b0, 1'b0);
        checks++;
        if (got_a.size() !== 0 || done_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arm_ignored: got %0d writes %0d pulses busy %b, expected 0 0 0",
                     got_a.size(), done_cnt, busy);
        end
    endtask

    task automatic test_reset_midframe();
        fmt = 2'b00; dec = 2'b00;
        clear_capture();
        pulse_arm();
        vsync = 1'b1; repeat (4) tick();
        vsync = 1'b0; repeat (3) tick();
        href = 1'b1;
        for (int b = 0; b < 9; b++) begin
            d = 8'($urandom_range(0, 255));
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({we, addr, dout, frame_done, busy, overflow} !== 36'd0 ||
            {s_we, s_addr, s_dout, s_frame_done, s_busy, s_overflow} !== 36'd0) begin
            errors++;
            $display("FAIL reset_async: got we=%b addr=%0d dout=%h busy=%b, expected all 0",
                     we, addr, dout, busy);
        end
        href = 1'b0; vsync = 1'b1;
        repeat (4) tick();
        single = 1'b0;
        reset  = 1'b0;
        repeat (2) tick();
        checks++;
        if (done_cnt !== 0 || sdone_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d/%0d pulses, expected 0", done_cnt, sdone_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            gen_frame(3, 6);
            fmt = 2'b00; dec = 2'b00;
            model_frame(0, 0);
            clear_capture();
            drive_frame(1'b0, 1'b0);
            checks++;
            if (got_a.size() !== kept.size() || done_cnt !== 1) begin
                errors++;
                $display("FAIL b2b_count[%0d]: got %0d writes %0d pulses, expected %0d 1",
                         f, got_a.size(), done_cnt, kept.size());
            end
            for (int i = 0; i < got_a.size() && i < kept.size(); i++) begin
                checks++;
                if (got_a[i] !== i || got_d[i] !== kept[i]) begin
                    errors++;
                    $display("FAIL b2b_write[%0d][%0d]: got addr %0d dout %h, expected addr %0d dout %h",
                             f, i, got_a[i], got_d[i], i, kept[i]);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_rearm[%0d]: got busy %b, expected 1", f, busy);
            end
        end
    endtask

    // Random sizes, formats and decimation; some frames end with vsync rising
    // on the final phase-1 byte.
    task automatic test_random();
        int f, dc;
        bit vl;
        single = 1'b1;
        repeat (8) tick();
        for (int n = 0; n < 6; n++) begin
            gen_frame(int'($urandom_range(1, 8)), 2 * int'($urandom_range(1, 8)));
            f  = int'($urandom_range(0, 3));
            dc = int'($urandom_range(0, 3));
            vl = 1'($urandom_range(0, 1));
            fmt = 2'(f); dec = 2'(dc);
            model_frame(f, dc);
            clear_capture();
            pulse_arm();
            drive_frame(1'b0, vl);
            checks++;
            if (got_a.size() !== kept.size() || done_cnt !== 1) begin
                errors++;
                $display("FAIL rand_count[%0d]: got %0d writes %0d pulses, expected %0d 1",
                         n, got_a.size(), done_cnt, kept.size());
            end
            for (int i = 0; i < got_a.size() && i < kept.size(); i++) begin
                checks++;
                if (got_a[i] !== i || got_d[i] !== kept[i]) begin
                    errors++;
                    $display("FAIL rand_write[%0d][%0d]: got addr %0d dout %h, expected addr %0d dout %h",
                             n, i, got_a[i], got_d[i], i, kept[i]);
                end
            end
            checks++;
            if (s_overflow !== (kept.size() > 10)) begin
                errors++;
                $display("FAIL rand_overflow[%0d]: got %b, expected %b", n, s_overflow, kept.size() > 10);
            end
        end
    endtask

    initial begin
        test_reset();
        gen_frame(4, 8);
        test_basic("basic", 4, 8, 0, 0);
        gen_frame(2, 4);
        test_basic("ovf_clear", 2, 4, 0, 0);
        test_formats();
        gen_frame(8, 16);
        test_basic("dec2", 8, 16, 0, 1);
        test_partial_arm();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
